// File: rtl/posit_round_param_if.sv
// posit_round_param_if: start/done/recieved handshake plus operand and result
// fields shared between the normaliser, the rounder and the encoder.
interface posit_round_param_if #(
  parameter int N  = 32,
  parameter int ES = 3,
  parameter int MW = 64,
  parameter int KW = 6
);
  logic          start;
  logic          recieved;
  logic [MW-1:0] shifted_mantissa;
  logic [KW-1:0] k_out;
  logic          sign_out;
  logic [ES-1:0] exp_out;
  logic [1:0]    rnd_mode;
  logic [N-1:0]  mantissa_out;
  logic [KW-1:0] k_final;
  logic [ES-1:0] exp_final;
  logic          sign_final;
  logic          inexact;
  logic          done;
  logic          init;
  modport master (
    output start, recieved, shifted_mantissa, k_out, sign_out, exp_out, rnd_mode,
    input  mantissa_out, k_final, exp_final, sign_final, inexact, done, init
  );
  modport slave (
    input  start, recieved, shifted_mantissa, k_out, sign_out, exp_out, rnd_mode,
    output mantissa_out, k_final, exp_final, sign_final, inexact, done, init
  );
endinterface

// File: rtl/posit_round_param.sv
// posit_round_param: fits the normalised fraction into the bits left over by
// regime and exponent, rounds it, and carries overflow into exponent/regime.
module posit_round_param #(
  parameter int N  = 32,
  parameter int ES = 3,
  parameter int MW = 64,
  parameter int KW = 6
) (
  input logic                clk,
  input logic                rst_n,
  posit_round_param_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CALC, ROUND, ADJUST, DONE} state_t;
  localparam int PB = N - 3 - ES;
  localparam int NB = N - 2 - ES;
  localparam logic [N-1:0] ONES = '1;
  state_t        state_q, state_d;
  logic [MW-3:0] mant_q;
  logic [KW-1:0] k_q, kf_q, kf_d;
  logic [ES-1:0] exp_q, ef_q, ef_d;
  logic [1:0]    mode_q;
  logic [N-1:0]  mask_q, mask_d, mo_q, mo_d, ext, low, kept, lsb;
  logic [N:0]    sum_q, sum_d;
  logic          sign_q, sf_q, guard_q, guard_d, sticky_q, sticky_d;
  logic          inx_q, done_q, init_q, rup, carry, wrap, sat;
  int            ki, raw, nbt;
  assign ext      = mant_q[MW-3 -: N];
  assign ki       = int'($signed(k_q));
  assign raw      = ki >= 0 ? PB - ki : NB + ki;
  assign nbt      = raw < 0 ? 0 : raw;
  assign mask_d   = ~(ONES >> nbt);
  assign low      = ONES >> (nbt + 1);
  assign guard_d  = |(ext & ~mask_d & ~low);
  assign sticky_d = (|(ext & low)) | (|mant_q[MW-3-N:0]);
  // lsb is the weight of the last kept bit; it is zero when nothing is kept,
  // which makes the nbt=0 case fall through as a plain truncation.
  assign kept  = ext & mask_q;
  assign lsb   = mask_q & ~(mask_q << 1);
  assign rup   = mode_q == 2'b01 ? guard_q & (sticky_q | (|(kept & lsb))) :
                 mode_q == 2'b10 ? guard_q | sticky_q : 1'b0;
  assign sum_d = {1'b0, kept} + (rup ? {1'b0, lsb} : '0);
  assign carry = sum_q[N];
  assign wrap  = carry && exp_q == '1;
  assign sat   = wrap && ki >= N - 2;
  assign mo_d  = !carry ? sum_q[N-1:0] & mask_q : sat ? mask_q : '0;
  assign ef_d  = !carry || sat ? exp_q : exp_q + 1'b1;
  assign kf_d  = sat ? KW'(N - 2) : wrap ? k_q + 1'b1 : k_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? CALC : IDLE;
      CALC:    state_d = ROUND;
      ROUND:   state_d = ADJUST;
      ADJUST:  state_d = DONE;
      DONE:    state_d = bus.recieved ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_q   <= '0;
      k_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mode_q   <= '0;
      mask_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      sum_q    <= '0;
      mo_q     <= '0;
      kf_q     <= '0;
      ef_q     <= '0;
      sf_q     <= 1'b0;
      inx_q    <= 1'b0;
      done_q   <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          mant_q <= bus.shifted_mantissa[MW-3:0];
          k_q    <= bus.k_out;
          sign_q <= bus.sign_out;
          exp_q  <= bus.exp_out;
          mode_q <= bus.rnd_mode;
          init_q <= 1'b1;
        end
        CALC: begin
          mask_q   <= mask_d;
          guard_q  <= guard_d;
          sticky_q <= sticky_d;
          init_q   <= 1'b0;
        end
        ROUND: sum_q <= sum_d;
        ADJUST: begin
          mo_q   <= mo_d;
          kf_q   <= kf_d;
          ef_q   <= ef_d;
          sf_q   <= sign_q;
          inx_q  <= guard_q | sticky_q;
          done_q <= 1'b1;
        end
        DONE: if (bus.recieved) done_q <= 1'b0;
        default: ;
      endcase
    end
  end
  assign bus.mantissa_out = mo_q;
  assign bus.k_final      = kf_q;
  assign bus.exp_final    = ef_q;
  assign bus.sign_final   = sf_q;
  assign bus.inexact      = inx_q;
  assign bus.done         = done_q;
  assign bus.init         = init_q;
endmodule

// File: tb/tb_posit_round_param.sv
// tb_posit_round_param: random and directed requests scored against an
// arithmetic model of posit fraction rounding; a monitor checks each result.
module tb_posit_round_param;
  localparam int N = 32, ES = 3, MW = 64, KW = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  posit_round_param_if #(.N(N), .ES(ES), .MW(MW), .KW(KW)) bus ();
  posit_round_param #(.N(N), .ES(ES), .MW(MW), .KW(KW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [31:0] mo;
    logic [5:0]  kf;
    logic [2:0]  ef;
    logic        sf;
    logic        inx;
  } res_t;
  res_t q[$];
  res_t cur;
  int   checks = 0, errors = 0;
  logic done_prev = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Rounding by integer arithmetic: keep the top nbt fraction bits as a number,
  // round that number, and detect overflow as reaching 2^nbt.
  function automatic res_t model(input logic [63:0] m, input logic [5:0] k, input logic s,
                                 input logic [2:0] e, input logic [1:0] mode);
    res_t   r;
    int     ki, nbt, drop;
    longint ext, kept, rem, half;
    bit     g, st, up;
    ki   = int'($signed(k));
    nbt  = ki >= 0 ? N - 3 - ES - ki : N - 2 - ES + ki;
    if (nbt < 0) nbt = 0;
    drop = N - nbt;
    ext  = longint'(m[61:30]);
    kept = ext >> drop;
    rem  = ext - (kept << drop);
    half = longint'(1) << (drop - 1);
    g    = rem >= half;
    st   = (rem % half) != 0 || m[29:0] != 0;
    up   = 1'b0;
    if (nbt > 0 && mode == 2'b01) up = g && (st || kept % 2 == 1);
    if (nbt > 0 && mode == 2'b10) up = g || st;
    kept = kept + longint'(up);
    r.sf = s; r.inx = g || st; r.kf = k; r.ef = e;
    if (kept == (longint'(1) << nbt)) begin
      r.mo = 32'd0;
      if (e != 3'd7) r.ef = e + 3'd1;
      else if (ki >= N - 2) begin
        r.kf = 6'(N - 2);
        r.mo = 32'(((longint'(1) << nbt) - 1) << drop);
      end else begin
        r.ef = 3'd0;
        r.kf = k + 6'd1;
      end
    end else r.mo = 32'(kept << drop);
    return r;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) done_prev = 1'b0;
    else begin
      if (bus.done && !done_prev) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          cur = q.pop_front();
          chk("mantissa_out", bus.mantissa_out, cur.mo);
          chk("k_final", bus.k_final, cur.kf);
          chk("exp_final", bus.exp_final, cur.ef);
          chk("sign_final", bus.sign_final, cur.sf);
          chk("inexact", bus.inexact, cur.inx);
        end
      end else if (bus.done) begin
        chk("hold_mantissa", bus.mantissa_out, cur.mo);
        chk("hold_exp_k", {bus.exp_final, bus.k_final}, {cur.ef, cur.kf});
      end
      done_prev = bus.done;
    end
  end
  task automatic drive(input logic [63:0] m, input logic [5:0] k, input logic s,
                       input logic [2:0] e, input logic [1:0] mode);
    bus.shifted_mantissa = m;
    bus.k_out = k;
    bus.sign_out = s;
    bus.exp_out = e;
    bus.rnd_mode = mode;
  endtask
  task automatic check_zero(input string name);
    chk({name, "_mant"}, bus.mantissa_out, 0);
    chk({name, "_k"}, bus.k_final, 0);
    chk({name, "_exp"}, bus.exp_final, 0);
    chk({name, "_flags"}, {bus.sign_final, bus.inexact, bus.done, bus.init}, 0);
  endtask
  task automatic run(input logic [63:0] m, input logic [5:0] k, input logic s, input logic [2:0] e,
                     input logic [1:0] mode, input int hold, input bit pulse);
    @(negedge clk);
    drive(m, k, s, e, mode);
    bus.start = 1'b1;
    q.push_back(model(m, k, s, e, mode));
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive({$urandom, $urandom}, 6'($urandom), 1'($urandom), 3'($urandom), 2'($urandom));
    bus.recieved = 1'($urandom);
    chk("init_pulse", bus.init, 1);
    @(posedge clk); #1;
    chk("init_clear", {bus.init, bus.done}, 0);
    @(posedge clk); #1;
    bus.recieved = 1'b0;
    chk("done_early", bus.done, 0);
    @(posedge clk); #1;
    chk("done_latency", bus.done, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.start = pulse;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("done_hold", {bus.done, bus.init}, 2'b10);
    end
    @(negedge clk);
    bus.recieved = 1'b1;
    bus.start = 1'($urandom);
    @(posedge clk); #1;
    bus.recieved = 1'b0;
    bus.start = 1'b0;
    chk("ack_done_low", bus.done, 0);
    @(posedge clk); #1;
    chk("no_queued_start", {bus.init, bus.done}, 0);
  endtask
  task automatic reset_mid();
    @(negedge clk);
    drive({$urandom, $urandom}, 6'd0, 1'b1, 3'd5, 2'b01);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rst_init", bus.init, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("rst_no_done", {bus.done, bus.mantissa_out}, 0);
    end
  endtask
  initial begin
    logic [63:0] m;
    bus.start = 1'b0;
    bus.recieved = 1'b0;
    drive(64'd0, 6'd0, 1'b0, 3'd0, 2'b00);
    #3;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run({2'b01, 32'hFFFF_FFFF, 30'd0}, 6'd0, 1'b0, 3'd2, 2'b00, 0, 1'b0);
    reset_mid();
    run({2'b01, 32'h0000_0020, 30'd0}, 6'd0, 1'b1, 3'd1, 2'b01, 1, 1'b0);
    run({2'b01, 32'h0000_0060, 30'd0}, 6'd0, 1'b0, 3'd1, 2'b01, 0, 1'b0);
    run({2'b01, 32'hFFFF_FFE0, 30'd0}, 6'd0, 1'b0, 3'd3, 2'b01, 0, 1'b0);
    run({2'b01, 32'hFFFF_FFE0, 30'd0}, 6'd0, 1'b1, 3'd7, 2'b01, 0, 1'b0);
    run({2'b01, 32'hFFFF_FFFF, 30'd0}, 6'b111101, 1'b0, 3'd4, 2'b00, 0, 1'b0);
    run({2'b01, 32'h0000_0001, 30'd0}, 6'b111101, 1'b0, 3'd4, 2'b10, 0, 1'b0);
    run({2'b01, 32'hFFFF_FFFF, 30'd5}, 6'd2, 1'b1, 3'd6, 2'b11, 10, 1'b1);
    run({2'b01, 32'hFFFF_FFFF, 30'd0}, 6'd29, 1'b0, 3'd7, 2'b10, 0, 1'b0);
    for (int t = 0; t < 60; t++) begin
      m = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) m[29:0] = '0;
      if ($urandom_range(0, 3) == 0) m[61:36] = '1;
      run(m, $urandom_range(0, 3) == 0 ? 6'($urandom) : 6'($urandom_range(0, 10) - 5),
          1'($urandom), 3'($urandom), 2'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
